ccff_chain_loader: RTL and testbench



---
 rtl/ccff_pkg.sv | 19 +
 rtl/ccff_chain_loader_if.sv | 20 ++
 rtl/ccff_word_serializer.sv | 59 +++++
 rtl/ccff_chain_loader.sv | 170 +++++++++++++++++
 tb/tb_ccff_chain_loader.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ccff_pkg.sv
// ---------------------------------------------------------------------------
// ccff_pkg
// Shared definitions for the configuration-chain loader:
//   - default bitstream word width and bit-counter width
//   - load-controller state encoding (ccff_ld_state_e)
// ---------------------------------------------------------------------------
package ccff_pkg;

    localparam int unsigned CCFF_WORD_W = 32;
    localparam int unsigned CCFF_CNT_W  = 20;

    typedef enum logic [1:0] {
        LD_IDLE  = 2'd0,
        LD_FETCH = 2'd1,
        LD_SHIFT = 2'd2,
        LD_DONE  = 2'd3
    } ccff_ld_state_e;

endpackage

// File: rtl/ccff_chain_loader_if.sv
// ---------------------------------------------------------------------------
// ccff_chain_loader_if
// Valid/ready bitstream word stream from the configuration host.
//   s_data  : bitstream word (host -> loader)
//   s_valid : s_data is valid (host -> loader)
//   s_ready : loader accepts the word this cycle (loader -> host)
// master = host side, slave = loader side.
// ---------------------------------------------------------------------------
interface ccff_chain_loader_if #(
    parameter int WORD_W = 32
) ();

    logic [WORD_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/ccff_word_serializer.sv
// ---------------------------------------------------------------------------
// ccff_word_serializer
// Holds one bitstream word and presents it LSB-first, one bit per advance.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   load_i     : capture data_i; bit 0 appears on head_o next cycle
//   data_i     : word to capture
//   advance_i  : step to the next bit (never asserted on the last bit)
//   head_o     : registered current bit
//   last_o     : current bit is bit WORD_W-1
// ---------------------------------------------------------------------------
module ccff_word_serializer #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [WORD_W-1:0] data_i,
    input  logic              advance_i,
    output logic              head_o,
    output logic              last_o
);

    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    logic [WORD_W-1:0] word_q;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  idx_d;
    logic              head_q;

    // Index of the bit that follows the current one.
    always_comb begin
        idx_d = idx_q + IDX_W'(1);
    end

    // Word register, bit index and registered head bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
            idx_q  <= '0;
            head_q <= 1'b0;
        end else if (load_i) begin
            word_q <= data_i;
            idx_q  <= '0;
            head_q <= data_i[0];
        end else if (advance_i) begin
            idx_q  <= idx_d;
            head_q <= word_q[idx_d];
        end else begin
            word_q <= word_q;
            idx_q  <= idx_q;
            head_q <= head_q;
        end
    end

    assign head_o = head_q;
    assign last_o = (idx_q == IDX_W'(WORD_W - 1));

endmodule

// File: rtl/ccff_chain_loader.sv
// ---------------------------------------------------------------------------
// ccff_chain_loader
// Streams a bitstream LSB-first into the ccff_head -> ccff_tail chain and,
// optionally, streams it a second time while comparing ccff_tail.
// Ports:
//   prog_clk, prog_reset : clock, synchronous active-high reset
//   start                : begin a load (ignored while busy)
//   bit_count, verify_en : chain length N and verify request, taken on start
//   s_if                 : bitstream word stream (slave side)
//   ccff_head, shift_en  : registered serial data and prog_clk gate enable
//   ccff_tail            : serial data returning from the chain tail
//   busy, done, error    : status (done is a pulse, error is sticky)
// ---------------------------------------------------------------------------
module ccff_chain_loader
    import ccff_pkg::*;
#(
    parameter int WORD_W = CCFF_WORD_W,
    parameter int CNT_W  = CCFF_CNT_W
) (
    input  logic                 prog_clk,
    input  logic                 prog_reset,
    input  logic                 start,
    input  logic [CNT_W-1:0]     bit_count,
    input  logic                 verify_en,
    ccff_chain_loader_if.slave   s_if,
    output logic                 ccff_head,
    output logic                 shift_en,
    input  logic                 ccff_tail,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    localparam logic [1:0] IDLE  = LD_IDLE;
    localparam logic [1:0] FETCH = LD_FETCH;
    localparam logic [1:0] SHIFT = LD_SHIFT;
    localparam logic [1:0] DONE  = LD_DONE;

    logic [1:0]       state_q,  state_d;
    logic [CNT_W-1:0] n_q,      n_d;
    logic [CNT_W-1:0] rem_q,    rem_d;
    logic             verify_q, verify_d;
    logic             pass_q,   pass_d;
    logic             err_q,    err_d;
    logic             ready_q;
    logic             shift_en_q;
    logic             busy_q;
    logic             done_q;

    logic             load_s;
    logic             advance_s;
    logic             ser_head_s;
    logic             ser_last_s;

    ccff_word_serializer #(.WORD_W(WORD_W)) u_ser (
        .clk       (prog_clk),
        .rst       (prog_reset),
        .load_i    (load_s),
        .data_i    (s_if.s_data),
        .advance_i (advance_s),
        .head_o    (ser_head_s),
        .last_o    (ser_last_s)
    );

    // Next-state logic: FSM, remaining-bit counter, pass tracking, verify.
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        rem_d     = rem_q;
        verify_d  = verify_q;
        pass_d    = pass_q;
        err_d     = err_q;
        load_s    = 1'b0;
        advance_s = 1'b0;

        // Second pass: the tail must reproduce what is being driven now.
        if (pass_q && shift_en_q && (ccff_tail != ser_head_s)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    if (bit_count == '0) begin
                        state_d = DONE;
                    end else begin
                        n_d      = bit_count;
                        verify_d = verify_en;
                        pass_d   = 1'b0;
                        rem_d    = bit_count;
                        state_d  = FETCH;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH: begin
                if (s_if.s_valid && ready_q) begin
                    load_s  = 1'b1;
                    state_d = SHIFT;
                end else begin
                    state_d = FETCH;
                end
            end
            SHIFT: begin
                rem_d = rem_q - CNT_W'(1);
                if (rem_q == CNT_W'(1)) begin
                    // Any unshifted bits left in the word are dropped here.
                    if (pass_q || !verify_q) begin
                        state_d = DONE;
                    end else begin
                        pass_d  = 1'b1;
                        rem_d   = n_q;
                        state_d = FETCH;
                    end
                end else if (ser_last_s) begin
                    state_d = FETCH;
                end else begin
                    advance_s = 1'b1;
                    state_d   = SHIFT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs, all derived from the next state so that
    // shift_en rises together with the head bit the serializer loads.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state_q    <= IDLE;
            n_q        <= '0;
            rem_q      <= '0;
            verify_q   <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= 1'b0;
            ready_q    <= 1'b0;
            shift_en_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            rem_q      <= rem_d;
            verify_q   <= verify_d;
            pass_q     <= pass_d;
            err_q      <= err_d;
            ready_q    <= (state_d == FETCH);
            shift_en_q <= (state_d == SHIFT);
            busy_q     <= (state_d == FETCH) || (state_d == SHIFT);
            done_q     <= (state_d == DONE);
        end
    end

    assign s_if.s_ready = ready_q;
    assign ccff_head    = ser_head_s;
    assign shift_en     = shift_en_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = err_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// ---------------------------------------------------------------------------
// tb_ccff_chain_loader
// Directed bench for ccff_chain_loader with a 40-bit chain model on the
// head/tail pins. Cycle numbers are counted from the start cycle (cycle 0).
// ---------------------------------------------------------------------------
module tb_ccff_chain_loader;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 20;

    logic              prog_clk = 1'b0;
    logic              prog_reset;
    logic              start;
    logic [CNT_W-1:0]  bit_count;
    logic              verify_en;
    logic              ccff_head;
    logic              shift_en;
    logic              ccff_tail;
    logic              busy;
    logic              done;
    logic              error;

    ccff_chain_loader_if #(.WORD_W(WORD_W)) s_if ();

    ccff_chain_loader #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
        .prog_clk   (prog_clk),
        .prog_reset (prog_reset),
        .start      (start),
        .bit_count  (bit_count),
        .verify_en  (verify_en),
        .s_if       (s_if),
        .ccff_head  (ccff_head),
        .shift_en   (shift_en),
        .ccff_tail  (ccff_tail),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 prog_clk = ~prog_clk;

    int errors = 0;
    int checks = 0;

    logic [WORD_W-1:0] words [0:1];

    // 40-bit chain model plus capture of every bit the chain receives.
    logic [39:0] chain = 40'd0;
    int          cap_n = 0;
    int          sh_cnt = 0;
    int          corrupt_idx = -1;
    logic        cap_bits [0:127];

    assign ccff_tail = chain[39];

    always @(posedge prog_clk) begin
        if (start && !busy && !prog_reset) begin
            cap_n  <= 0;
            sh_cnt <= 0;
        end else if (shift_en) begin
            if (cap_n < 128) cap_bits[cap_n] <= ccff_head;
            cap_n  <= cap_n + 1;
            chain  <= {chain[38:0], ccff_head ^ (sh_cnt == corrupt_idx)};
            sh_cnt <= sh_cnt + 1;
        end
    end

    // Runs one load, feeding words[] (repeated for a verify pass).
    // gap_len: FETCH cycles with s_valid=0 before the second word.
    // restart_at: cycle at which an extra start (with N=7) is pulsed.
    task automatic run_load(input int n, input bit ver, input int gap_len,
                            input int restart_at,
                            output int done_cyc, output int done_cnt,
                            output int ready_cnt, output int shift_cnt,
                            output logic err1);
        int wi;
        int gap_rem;
        int nw;
        nw = (n + WORD_W - 1) / WORD_W;
        if (nw == 0) nw = 1;
        done_cyc = -1; done_cnt = 0; ready_cnt = 0; shift_cnt = 0;
        err1 = 1'bx;
        wi = 0; gap_rem = 0;
        @(negedge prog_clk);
        bit_count = CNT_W'(n);
        verify_en = ver;
        start = 1'b1;
        s_if.s_valid = 1'b0;
        for (int t = 1; t < 400; t++) begin
            @(negedge prog_clk);
            start     = (t == restart_at);
            bit_count = (t == restart_at) ? CNT_W'(7) : CNT_W'(n);
            if (t == 1) err1 = error;
            if (shift_en) shift_cnt++;
            if (s_if.s_ready) ready_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = t;
            end
            if (s_if.s_ready && gap_rem > 0) begin
                s_if.s_valid = 1'b0;
                gap_rem--;
            end else begin
                s_if.s_valid = (done_cyc < 0);
                s_if.s_data  = words[wi % nw];
                if (s_if.s_ready) begin
                    wi++;
                    if (wi == 1) gap_rem = gap_len;
                end
            end
            if (done_cyc >= 0 && t >= done_cyc + 3) break;
        end
        s_if.s_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        prog_reset = 1'b1;
        repeat (3) @(negedge prog_clk);
        checks++; if (s_if.s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready got=%b exp=0", s_if.s_ready); end
        checks++; if (ccff_head !== 1'b0) begin errors++; $display("FAIL reset_head got=%b exp=0", ccff_head); end
        checks++; if (shift_en !== 1'b0) begin errors++; $display("FAIL reset_shift_en got=%b exp=0", shift_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got=%b exp=0", error); end
        prog_reset = 1'b0;
        @(negedge prog_clk);
    endtask

    task automatic test_basic();
        int dc, dn, rc, sc, bad;
        logic e1;
        run_load(40, 1'b0, 0, -1, dc, dn, rc, sc, e1);
        checks++; if (dc !== 43) begin errors++; $display("FAIL basic_done_cycle got=%0d exp=43", dc); end
        checks++; if (dn !== 1) begin errors++; $display("FAIL basic_done_count got=%0d exp=1", dn); end
        checks++; if (sc !== 40) begin errors++; $display("FAIL basic_shift_cycles got=%0d exp=40", sc); end
        checks++; if (cap_n !== 40) begin errors++; $display("FAIL basic_chain_bits got=%0d exp=40", cap_n); end
        checks++; if (rc !== 2) begin errors++; $display("FAIL basic_ready_cycles got=%0d exp=2", rc); end
        bad = 0;
        for (int i = 0; i < 40; i++) if (cap_bits[i] !== words[i / 32][i % 32]) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL basic_bit_order wrong_bits=%0d exp=0", bad); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got=%b exp=0", busy); end
    endtask

    task automatic test_stall();
        int dc, dn, rc, sc, bad;
        logic e1;
        run_load(40, 1'b0, 5, -1, dc, dn, rc, sc, e1);
        checks++; if (dc !== 48) begin errors++; $display("FAIL stall_done_cycle got=%0d exp=48", dc); end
        checks++; if (sc !== 40) begin errors++; $display("FAIL stall_shift_cycles got=%0d exp=40", sc); end
        checks++; if (rc !== 7) begin errors++; $display("FAIL stall_ready_cycles got=%0d exp=7", rc); end
        bad = 0;
        for (int i = 0; i < 40; i++) if (cap_bits[i] !== words[i / 32][i % 32]) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL stall_bit_order wrong_bits=%0d exp=0", bad); end
    endtask

    task automatic test_zero_len();
        int dc, dn, rc, sc;
        logic e1;
        run_load(0, 1'b0, 0, -1, dc, dn, rc, sc, e1);
        checks++; if (dc !== 1) begin errors++; $display("FAIL zero_done_cycle got=%0d exp=1", dc); end
        checks++; if (dn !== 1) begin errors++; $display("FAIL zero_done_count got=%0d exp=1", dn); end
        checks++; if (rc !== 0) begin errors++; $display("FAIL zero_ready_cycles got=%0d exp=0", rc); end
        checks++; if (sc !== 0) begin errors++; $display("FAIL zero_shift_cycles got=%0d exp=0", sc); end
    endtask

    task automatic test_verify();
        int dc, dn, rc, sc;
        logic e1;
        corrupt_idx = -1;
        run_load(40, 1'b1, 0, -1, dc, dn, rc, sc, e1);
        checks++; if (dc !== 85) begin errors++; $display("FAIL verify_done_cycle got=%0d exp=85", dc); end
        checks++; if (sc !== 80) begin errors++; $display("FAIL verify_shift_cycles got=%0d exp=80", sc); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL verify_clean_error got=%b exp=0", error); end
        // Flip shift 5 of pass 1 inside the chain model.
        corrupt_idx = 5;
        run_load(40, 1'b1, 0, -1, dc, dn, rc, sc, e1);
        corrupt_idx = -1;
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL verify_corrupt_error got=%b exp=1", error); end
        repeat (5) @(negedge prog_clk);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL verify_error_sticky got=%b exp=1", error); end
        run_load(40, 1'b0, 0, -1, dc, dn, rc, sc, e1);
        checks++; if (e1 !== 1'b0) begin errors++; $display("FAIL verify_error_cleared got=%b exp=0", e1); end
    endtask

    task automatic test_reset_mid();
        int dc, dn, rc, sc, bad;
        logic e1;
        @(negedge prog_clk);
        bit_count = CNT_W'(40); verify_en = 1'b0; start = 1'b1;
        s_if.s_valid = 1'b1; s_if.s_data = words[0];
        @(negedge prog_clk);
        start = 1'b0;
        repeat (5) @(negedge prog_clk);
        checks++; if (shift_en !== 1'b1) begin errors++; $display("FAIL midrst_shifting got=%b exp=1", shift_en); end
        prog_reset = 1'b1;
        s_if.s_valid = 1'b0;
        @(negedge prog_clk);
        checks++; if (s_if.s_ready !== 1'b0) begin errors++; $display("FAIL midrst_s_ready got=%b exp=0", s_if.s_ready); end
        checks++; if (ccff_head !== 1'b0) begin errors++; $display("FAIL midrst_head got=%b exp=0", ccff_head); end
        checks++; if (shift_en !== 1'b0) begin errors++; $display("FAIL midrst_shift_en got=%b exp=0", shift_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b exp=0", done); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL midrst_error got=%b exp=0", error); end
        prog_reset = 1'b0;
        run_load(40, 1'b0, 0, -1, dc, dn, rc, sc, e1);
        checks++; if (dc !== 43) begin errors++; $display("FAIL midrst_restart_done got=%0d exp=43", dc); end
        bad = 0;
        for (int i = 0; i < 40; i++) if (cap_bits[i] !== words[i / 32][i % 32]) bad++;
        checks++; if (bad !== 0 || cap_n !== 40) begin errors++; $display("FAIL midrst_restart_bits wrong_bits=%0d count=%0d exp=0,40", bad, cap_n); end
    endtask

    task automatic test_back_to_back();
        int dc, dn, rc, sc, bad;
        logic e1;
        run_load(40, 1'b0, 0, 10, dc, dn, rc, sc, e1);
        checks++; if (dc !== 43) begin errors++; $display("FAIL b2b_done_cycle got=%0d exp=43", dc); end
        checks++; if (dn !== 1) begin errors++; $display("FAIL b2b_done_count got=%0d exp=1", dn); end
        checks++; if (sc !== 40) begin errors++; $display("FAIL b2b_shift_cycles got=%0d exp=40", sc); end
        bad = 0;
        for (int i = 0; i < 40; i++) if (cap_bits[i] !== words[i / 32][i % 32]) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL b2b_bit_order wrong_bits=%0d exp=0", bad); end
    endtask

    initial begin
        words[0] = 32'hA5C3_0FB6;
        words[1] = 32'h5A3C_E10D;
        prog_reset   = 1'b1;
        start        = 1'b0;
        bit_count    = '0;
        verify_en    = 1'b0;
        s_if.s_valid = 1'b0;
        s_if.s_data  = '0;
        test_reset();
        test_basic();
        test_stall();
        test_zero_len();
        test_verify();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
